// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icodes and memory-stage state encoding shared by the data path.
package y86_pkg;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_byte_ram.sv
// rtl/mem_byte_ram.sv - byte-addressed data RAM, one BEAT_BYTES-lane port, big-endian lane order.
module mem_byte_ram #(
  parameter int MEM_BYTES  = 4096,
  parameter int BEAT_BYTES = 8,
  localparam int AW = $clog2(MEM_BYTES),
  localparam int BW = BEAT_BYTES * 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [BW-1:0] wdata,
  output logic [BW-1:0] rdata
);

  logic [7:0] mem [MEM_BYTES];

  // Lane 0 is the most significant byte and lands at the lowest address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BEAT_BYTES; i++) begin
        mem[addr + AW'(i)] <= wdata[BW-1-8*i -: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      rdata[BW-1-8*i -: 8] = mem[addr + AW'(i)];
    end
  end

endmodule

// File: rtl/mem_stage_pipelined.sv
// rtl/mem_stage_pipelined.sv - Y86-64 data-memory stage: decode, bounds check, multi-beat RAM access.
module mem_stage_pipelined
  import y86_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MEM_BYTES  = 4096,
  parameter int BEAT_BYTES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              resp_valid,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error,
  output logic [DATA_W-1:0] readback
);

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int BEATS      = WORD_BYTES / BEAT_BYTES;
  localparam int BEAT_W     = BEAT_BYTES * 8;
  localparam int AW         = $clog2(MEM_BYTES);
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(MEM_BYTES - WORD_BYTES);

  mem_state_t          state_q, state_d;
  logic [CNT_W-1:0]    beat_q;
  logic [AW-1:0]       addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   acc_q;
  logic                write_q;
  logic                ready_en_q;

  logic                dec_mem, dec_write, in_range, accept, last_beat, ram_we;
  logic [DATA_W-1:0]   dec_addr, dec_data, assembled;
  logic [AW-1:0]       beat_off, ram_addr;
  logic [BEAT_W-1:0]   beat_wdata, ram_rdata;

  always_comb begin
    dec_mem   = 1'b1;
    dec_write = 1'b0;
    dec_addr  = valE;
    dec_data  = valA;
    case (icode)
      I_RMMOVQ: dec_write = 1'b1;
      I_MRMOVQ: dec_write = 1'b0;
      I_CALL: begin
        dec_write = 1'b1;
        dec_data  = valP;
      end
      I_RET:    dec_addr  = valA;
      I_PUSHQ:  dec_write = 1'b1;
      I_POPQ:   dec_addr  = valA;
      default:  dec_mem   = 1'b0;
    endcase
  end

  // Full-width compare so high address bits can never alias into the RAM.
  assign in_range  = (dec_addr <= LIMIT);
  assign accept    = req_valid && req_ready;
  assign last_beat = (beat_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_we     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = ready_en_q;
        if (req_valid && ready_en_q) state_d = (dec_mem && in_range) ? ACCESS : DONE;
      end
      ACCESS: begin
        ram_we = write_q;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_off   = '0;
    beat_wdata = '0;
    assembled  = acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == CNT_W'(k)) begin
        beat_off   = AW'(k * BEAT_BYTES);
        beat_wdata = wdata_q[DATA_W-1-k*BEAT_W -: BEAT_W];
        assembled[DATA_W-1-k*BEAT_W -: BEAT_W] = ram_rdata;
      end
    end
  end

  assign ram_addr = addr_q + beat_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      beat_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      write_q    <= 1'b0;
      dmem_error <= 1'b0;
      valM       <= '0;
      readback   <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        addr_q     <= dec_addr[AW-1:0];
        wdata_q    <= dec_data;
        write_q    <= dec_write;
        dmem_error <= dec_mem && !in_range;
        beat_q     <= '0;
      end
      if (state_q == ACCESS) begin
        acc_q <= assembled;
        if (last_beat) begin
          beat_q <= '0;
          if (write_q) begin
            readback <= wdata_q;
          end else begin
            valM     <= assembled;
            readback <= assembled;
          end
        end else begin
          beat_q <= beat_q + CNT_W'(1);
        end
      end
    end
  end

  mem_byte_ram #(
    .MEM_BYTES  (MEM_BYTES),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (beat_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// tb/tb_mem_stage_pipelined.sv - directed vectors for mem_stage_pipelined with 8-byte and 2-byte beats.
module tb_mem_stage_pipelined;

  logic        clk;
  logic        rst_a, rst_b;
  logic        vld_a, rdy_a, resp_a, err_a;
  logic        vld_b, rdy_b, resp_b, err_b;
  logic [3:0]  ic_a, ic_b;
  logic [63:0] va_a, ve_a, vp_a, vm_a, rb_a;
  logic [63:0] va_b, ve_b, vp_b, vm_b, rb_b;

  int checks = 0;
  int errors = 0;

  mem_stage_pipelined #(.DATA_W(64), .MEM_BYTES(4096), .BEAT_BYTES(8)) dut_a (
    .clk(clk), .rst_n(rst_a), .req_valid(vld_a), .req_ready(rdy_a), .icode(ic_a),
    .valA(va_a), .valE(ve_a), .valP(vp_a), .resp_valid(resp_a), .valM(vm_a),
    .dmem_error(err_a), .readback(rb_a)
  );

  mem_stage_pipelined #(.DATA_W(64), .MEM_BYTES(4096), .BEAT_BYTES(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .req_valid(vld_b), .req_ready(rdy_b), .icode(ic_b),
    .valA(va_b), .valE(ve_b), .valP(vp_b), .resp_valid(resp_b), .valM(vm_b),
    .dmem_error(err_b), .readback(rb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one request; lat counts negedges after the accepting edge up to the response.
  task automatic do_req(input bit sel, input logic [3:0] ic, input logic [63:0] a, e, p,
                        output int lat, output int low, output logic [63:0] vm, rb,
                        output logic er);
    logic rdy, rsp;
    lat = 0; low = 0; vm = '0; rb = '0; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel ? rdy_b : rdy_a) === 1'b1) break;
    end
    if (sel) begin vld_b = 1'b1; ic_b = ic; va_b = a; ve_b = e; vp_b = p; end
    else     begin vld_a = 1'b1; ic_a = ic; va_a = a; ve_a = e; vp_a = p; end
    @(posedge clk);
    #1;
    if (sel) begin
      vld_b = 1'b0; ic_b = 4'($urandom); va_b = {$urandom, $urandom};
      ve_b = {$urandom, $urandom}; vp_b = {$urandom, $urandom};
    end else begin
      vld_a = 1'b0; ic_a = 4'($urandom); va_a = {$urandom, $urandom};
      ve_a = {$urandom, $urandom}; vp_a = {$urandom, $urandom};
    end
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      rdy = sel ? rdy_b : rdy_a;
      rsp = sel ? resp_b : resp_a;
      if (rdy !== 1'b1) low++;
      if (rsp === 1'b1 && lat == 0) begin
        lat = i;
        vm  = sel ? vm_b : vm_a;
        rb  = sel ? rb_b : rb_a;
        er  = sel ? err_b : err_a;
      end
      if (rdy === 1'b1) break;
    end
  endtask

  typedef struct {
    logic [3:0]  ic;
    logic [63:0] va, ve, vp;
    int          lat;
    logic        err;
    logic [63:0] vm, rb;
  } vec_t;

  localparam logic [63:0] WRD = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] AAA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] FIV = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PSH = 64'h1122_3344_5566_7788;

  vec_t tv [14];

  initial begin
    int          lat, low;
    logic [63:0] vm, rb;
    logic        er;
    bit          seen;

    tv[0]  = '{4'h4, WRD, 64'd16, 64'd0, 2, 1'b0, 64'd0, WRD};
    tv[1]  = '{4'h5, 64'd0, 64'd16, 64'd0, 2, 1'b0, WRD, WRD};
    tv[2]  = '{4'h4, AAA, 64'd4088, 64'd0, 2, 1'b0, WRD, AAA};
    tv[3]  = '{4'h4, FIV, 64'd4089, 64'd0, 1, 1'b1, WRD, AAA};
    tv[4]  = '{4'h4, FIV, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1, 1'b1, WRD, AAA};
    tv[5]  = '{4'h5, 64'd0, 64'd4088, 64'd0, 2, 1'b0, AAA, AAA};
    tv[6]  = '{4'h8, 64'hDEAD, 64'h100, 64'h40, 2, 1'b0, AAA, 64'h40};
    tv[7]  = '{4'h9, 64'h100, 64'd8, 64'd0, 2, 1'b0, 64'h40, 64'h40};
    tv[8]  = '{4'hB, 64'h100, 64'd0, 64'd0, 2, 1'b0, 64'h40, 64'h40};
    tv[9]  = '{4'h2, 64'd16, 64'd16, 64'd0, 1, 1'b0, 64'h40, 64'h40};
    tv[10] = '{4'hA, PSH, 64'h200, 64'd0, 2, 1'b0, 64'h40, PSH};
    tv[11] = '{4'h5, 64'd0, 64'h200, 64'd0, 2, 1'b0, PSH, PSH};
    tv[12] = '{4'h5, 64'd0, 64'd4089, 64'd0, 1, 1'b1, PSH, PSH};
    tv[13] = '{4'h5, 64'd0, 64'd16, 64'd0, 2, 1'b0, WRD, WRD};

    rst_a = 1'b0; rst_b = 1'b0;
    vld_a = 1'b0; ic_a = '0; va_a = '0; ve_a = '0; vp_a = '0;
    vld_b = 1'b0; ic_b = '0; va_b = '0; ve_b = '0; vp_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp", 64'(resp_a), 64'd0);
    chk("rst_ready", 64'(rdy_a), 64'd0);
    chk("rst_valM", vm_a, 64'd0);
    chk("rst_readback", rb_a, 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(rdy_a), 64'd1);

    for (int i = 0; i < 14; i++) begin
      do_req(1'b0, tv[i].ic, tv[i].va, tv[i].ve, tv[i].vp, lat, low, vm, rb, er);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tv[i].lat));
      chk($sformatf("v%0d_ready_low", i), 64'(low), 64'(tv[i].lat));
      chk($sformatf("v%0d_err", i), 64'(er), 64'(tv[i].err));
      chk($sformatf("v%0d_valM", i), vm, tv[i].vm);
      chk($sformatf("v%0d_readback", i), rb, tv[i].rb);
    end
    chk("byte16", 64'(dut_a.u_ram.mem[16]), 64'h01);
    chk("byte23", 64'(dut_a.u_ram.mem[23]), 64'hEF);

    // Two-byte beats: four beats per word.
    do_req(1'b1, 4'h4, 64'h1111_2222_3333_4444, 64'd0, 64'd0, lat, low, vm, rb, er);
    chk("b_wr_lat", 64'(lat), 64'd5);
    chk("b_wr_ready_low", 64'(low), 64'd5);
    chk("b_wr_readback", rb, 64'h1111_2222_3333_4444);
    do_req(1'b1, 4'h5, 64'd0, 64'd0, 64'd0, lat, low, vm, rb, er);
    chk("b_rd_lat", 64'(lat), 64'd5);
    chk("b_rd_valM", vm, 64'h1111_2222_3333_4444);

    // Reset after two committed write beats leaves a partial word behind.
    @(negedge clk);
    vld_b = 1'b1; ic_b = 4'h4; va_b = 64'hAABB_CCDD_EEFF_0011; ve_b = 64'd0; vp_b = 64'd0;
    @(posedge clk);
    #1 vld_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_b = 1'b0;
    #1;
    chk("b_abort_valM", vm_b, 64'd0);
    chk("b_abort_readback", rb_b, 64'd0);
    chk("b_abort_err", 64'(err_b), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_b !== 1'b0) seen = 1'b1;
    end
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_b !== 1'b0) seen = 1'b1;
    end
    chk("b_abort_no_resp", 64'(seen), 64'd0);
    do_req(1'b1, 4'h5, 64'd0, 64'd0, 64'd0, lat, low, vm, rb, er);
    chk("b_partial_lat", 64'(lat), 64'd5);
    chk("b_partial_valM", vm, 64'hAABB_CCDD_3333_4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipelined.md
# mem_stage_pipelined

Parametrised data-memory stage for the sequential Y86-64 processor. It sits between execute and write-back and serves the six memory instructions (rmmovq, mrmovq, call, ret, pushq, popq) against a byte-addressed data RAM. A word moves in one or more beats, with the beat width set by a parameter. The block has a valid/ready request handshake, a one-cycle response pulse, bounds checking with a `dmem_error` flag, and a registered `readback` of the last word transferred.

## Interface
- `DATA_W`, 64: word width in bits; multiple of 8.
- `MEM_BYTES`, 4096: RAM size in bytes.
- `BEAT_BYTES`, 8: bytes moved per cycle; must divide `DATA_W/8`. `BEATS = DATA_W/8/BEAT_BYTES`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  stage can accept a request.
- `icode`  in  4  instruction code.
- `valA`  in  DATA_W  store data, or read address for ret/popq.
- `valE`  in  DATA_W  address for rmmovq/mrmovq/call/pushq.
- `valP`  in  DATA_W  return address stored by call.
- `resp_valid`  out  1  one-cycle completion pulse.
- `valM`  out  DATA_W  loaded word.
- `dmem_error`  out  1  out-of-range access; qualified by `resp_valid`.
- `readback`  out  DATA_W  word written or read by the last completed access.

## Operation
- Decode when a request is accepted; latch address, data and direction.
  - icode 4: write valA at valE.
  - icode 5: read at valE.
  - icode 8: write valP at valE.
  - icode 9: read at valA.
  - icode A: write valA at valE.
  - icode B: read at valA.
  - Any other icode: no access.
- Byte order: the most significant byte goes to the lowest address. Beat k covers bytes `addr + k*BEAT_BYTES` through `addr + (k+1)*BEAT_BYTES - 1`.
- Bounds check: compare the full DATA_W-bit address. The access is in range only if `addr <= MEM_BYTES - DATA_W/8`.
  - Out of range: no RAM access, `dmem_error = 1`, `valM` and `readback` unchanged.
  - The address sum must never wrap.
- FSM has three states:
  - IDLE: `req_ready = 1`. On accept, go to ACCESS for an in-range memory icode; otherwise go to DONE.
  - ACCESS: one beat per cycle, beat counter 0..BEATS-1. After the last beat, go to DONE.
  - DONE: `resp_valid = 1`; next state is IDLE.
- Reads assemble `valM` beat by beat. `valM` and `readback` update together on the edge entering DONE. Writes set `readback` to the stored word; `valM` is held.
- Non-memory icode: `resp_valid` pulses with `dmem_error = 0`, and no outputs other than the pulse change.

## Timing
- Reset (async assert, any state): state = IDLE, beat counter = 0, `resp_valid = 0`, `dmem_error = 0`, `valM = 0`, `readback = 0`.
- `req_ready` goes to 1 on the first edge after reset is released. RAM contents are not reset.
- Accept occurs on the edge where `req_valid && req_ready`. Requests are never accepted outside IDLE, so back-to-back requests are impossible.
- Memory access: `resp_valid` is high in the cycle following the BEATS-th edge after the accepting edge.
- Non-memory or error request: `resp_valid` is high in the cycle right after the accepting edge.
- `resp_valid` stays high exactly one cycle. `req_ready` returns high on the next edge, so the minimum request spacing is BEATS+2 cycles.
- Each write beat commits at its own edge. Reset during ACCESS aborts the access: beats already committed stay in RAM (a partial write) and no response is issued.
- Input values matter only at the accepting edge; changes afterwards have no effect.

## Structure
- Shared package `y86_pkg` holds:
  - icode localparams: `I_RMMOVQ = 4'h4`, `I_MRMOVQ = 4'h5`, `I_CALL = 4'h8`, `I_RET = 4'h9`, `I_PUSHQ = 4'hA`, `I_POPQ = 4'hB`.
  - The `mem_state_t` enum {IDLE, ACCESS, DONE}.
- Sub-module `mem_byte_ram`:
  - Parameters `MEM_BYTES`, `BEAT_BYTES`.
  - One read/write port of BEAT_BYTES lanes; synchronous write, combinational read.
  - Contains the byte array; the stage holds only the FSM, counter, latches and assembly.

## Test plan
- Reset released, then rmmovq `valA = 64'h0123456789ABCDEF`, `valE = 16`, followed by mrmovq `valE = 16` -> byte 16 = 8'h01, byte 23 = 8'hEF; `valM = 64'h0123456789ABCDEF`; `readback` matches; `dmem_error = 0`.
- `BEAT_BYTES = 2`, write at `valE = 0` -> `resp_valid` high 4 edges after accept; `req_ready` low for 5 cycles in total.
- Write at `valE = MEM_BYTES - 8` succeeds. Write at `valE = MEM_BYTES - 7`, and at `valE = 64'hFFFF_FFFF_FFFF_FFF8`, each give `dmem_error = 1` with RAM and `valM` unchanged.
- call `valP = 64'h40`, `valE = 64'h100`, then ret `valA = 64'h100` -> `valM = 64'h40`; a following popq at the same address also returns 64'h40.
- icode 2 (rrmovq) -> `resp_valid` high the cycle after accept; `valM` and `dmem_error` unchanged from their prior values.
- `BEAT_BYTES = 2`, assert `rst_n` low after 2 write beats -> no `resp_valid`; bytes 0–3 hold new data, bytes 4–7 hold old data; all outputs read 0.
